xmuladdlite_sink: RTL and testbench
===================================

Name: xmuladdlite_sink

Overview:
- Receive-side companion of the multiply-accumulate lite unit.
- Watches a result flow word and, at the end of each accumulation window, captures the finished result (or the high/low pair in double-word mode).
- Writes captured words to a data-memory write port through an internal address counter, and pulses done after the configured number of windows.
- Sits between a functional-unit flow output and a Versat memory port.

Parameters:
DATA_W, 32, flow/memory data width
ADDR_W, 10, memory address and iteration counter width
PERIOD_W, 10, window length and delay counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
run  in  1  start pulse; sampled only in IDLE
iterations  in  ADDR_W  number of windows to capture; 0 = no operation
period  in  PERIOD_W  window length in cycles; 0 treated as 1
delay  in  PERIOD_W  cycles between run acceptance and window 0 phase 0
pair  in  1  1 = capture two words per window (high, then low)
start_addr  in  ADDR_W  first write address
data_in  in  DATA_W  result flow word
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  write address (registered)
mem_data  out  DATA_W  write data (registered)
busy  out  1  high in DELAY and RUN
done  out  1  one-cycle pulse after last write

Behaviour:
- Reset: all outputs and internal state are 0; FSM goes to IDLE. Asserting rst mid-operation aborts immediately with no further writes and no done pulse.
- Configuration inputs (iterations, period, delay, pair, start_addr) are latched on run acceptance and ignored afterwards.
- Effective period P = max(period, 1).
- pair_eff = pair AND P >= 2.
- FSM states: IDLE, DELAY, RUN, DONE.
- IDLE, run=1, iterations!=0:
  - latch configuration; addr counter = start_addr; window counter = 0; phase = 0.
  - go to DELAY if delay!=0, else RUN.
- IDLE, run=1, iterations=0: stay in IDLE; no done pulse.
- DELAY: delay counter loaded with delay at acceptance and decremented each cycle; move to RUN in the cycle it reaches 1. After acceptance exactly delay cycles elapse before the first RUN cycle.
- RUN: phase counts 0..P-1 and wraps to 0; the window counter increments on wrap.
- Capture, pair_eff=0: at phase P-1, sample data_in; addr += 1.
- Capture, pair_eff=1:
  - phase P-2: sample data_in as high word to addr.
  - phase P-1: sample data_in as low word to addr+1.
  - addr += 2 per window.
- Write timing: each capture produces mem_we=1 with mem_addr and mem_data on the following cycle (latency 1). mem_we is 0 on all other cycles.
- Address counter wraps modulo 2^ADDR_W silently.
- After the capture at phase P-1 of window iterations-1, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, coincident with the last mem_we; then IDLE.
- run while busy or in DONE is ignored.
- run in the cycle after DONE (IDLE) is accepted normally (back-to-back runs).
- busy=1 in DELAY and RUN, else 0.

Test Plan:
- Basic: start_addr=0, iterations=3, period=4, delay=0, pair=0, data_in=cycle index k starting at 0 on the acceptance cycle+1 → writes (0,3),(1,7),(2,11), each one cycle after its sample; done coincides with the third mem_we; busy high for 12 cycles.
- Delay: same as Basic with delay=5 → each sampled value is shifted by +5 (8,12,16); first mem_we 9 cycles after acceptance.
- Pair: start_addr=0x10, iterations=2, period=3, pair=1 → writes addr 0x10,0x11,0x12,0x13 with data from phases 1,2 of each window; done with the 0x13 write.
- Degenerate: period=0 with iterations=4 → a write every cycle, addr start..start+3. pair=1 with period=1 → single-word behaviour. iterations=0 → no writes, no done, busy stays 0.
- Wrap and back-to-back:
  - start_addr=2^ADDR_W-1, iterations=2 → addresses max then 0.
  - run held high throughout → second operation starts the cycle after DONE; mid-run pulses are ignored.
- Reset mid-RUN after 1 of 3 windows → mem_we, busy and done are 0 immediately and stay 0. A new run is then accepted and restarts from start_addr.

Source files
------------

// File: rtl/xmuladdlite_sink.sv
// Receive side of the multiply-accumulate lite unit: captures the end-of-window
// result (or high/low pair) from the flow and writes it to memory, pulsing done at the end.
module xmuladdlite_sink #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [ADDR_W-1:0]   iterations,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] delay,
    input  logic                pair,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_W-1:0]     r_iter;
    logic [ADDR_W-1:0]     r_win;
    logic [ADDR_W-1:0]     r_addr;
    logic [PERIOD_W-1:0]   r_per;
    logic [PERIOD_W-1:0]   r_phase;
    logic [PERIOD_W-1:0]   r_dly;
    logic                  r_pair;

    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_data;

    logic                  w_accept;
    logic [PERIOD_W-1:0]   w_per_eff;
    logic                  w_last_ph;
    logic                  w_hi_ph;
    logic                  w_last_win;
    logic                  w_cap;

    assign w_accept   = (r_state == S_IDLE) && run && (iterations != '0);
    assign w_per_eff  = (period == '0) ? PERIOD_W'(1) : period;
    assign w_last_ph  = (r_phase == r_per - PERIOD_W'(1));
    // r_pair is only ever set with r_per >= 2, so r_per - 2 cannot underflow here
    assign w_hi_ph    = r_pair && (r_phase == r_per - PERIOD_W'(2));
    assign w_last_win = (r_win == r_iter - ADDR_W'(1));
    assign w_cap      = (r_state == S_RUN) && (w_last_ph || w_hi_ph);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (delay != '0) ? S_DELAY : S_RUN;
                end
            end
            S_DELAY: begin
                if (r_dly == PERIOD_W'(1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_ph && w_last_win) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter  <= '0;
            r_win   <= '0;
            r_addr  <= '0;
            r_per   <= '0;
            r_phase <= '0;
            r_dly   <= '0;
            r_pair  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iter  <= iterations;
                r_per   <= w_per_eff;
                r_pair  <= pair && (w_per_eff >= PERIOD_W'(2));
                r_dly   <= delay;
                r_addr  <= start_addr;
                r_win   <= '0;
                r_phase <= '0;
            end else if (r_state == S_DELAY) begin
                r_dly <= r_dly - PERIOD_W'(1);
            end else if (r_state == S_RUN) begin
                if (w_last_ph) begin
                    r_phase <= '0;
                    r_win   <= r_win + ADDR_W'(1);
                end else begin
                    r_phase <= r_phase + PERIOD_W'(1);
                end
                // one address per captured word; pair mode captures two per window
                if (w_cap) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_we <= w_cap;
            if (w_cap) begin
                r_mem_addr <= r_addr;
                r_mem_data <= data_in;
            end
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign busy     = (r_state == S_DELAY) || (r_state == S_RUN);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_xmuladdlite_sink.sv
// Directed and randomized checks of xmuladdlite_sink against a window/capture
// schedule computed from the configuration.
module tb_xmuladdlite_sink;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int PERIOD_W = 10;
    localparam int AMOD     = 1 << ADDR_W;
    localparam int MAXC     = 128;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                run = 1'b0;
    logic [ADDR_W-1:0]   iterations = '0;
    logic [PERIOD_W-1:0] period = '0;
    logic [PERIOD_W-1:0] delay = '0;
    logic                pair = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic [DATA_W-1:0]   data_in = '0;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                busy;
    logic                done;

    int n_chk = 0;
    int n_err = 0;

    xmuladdlite_sink #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .iterations(iterations),
        .period(period), .delay(delay), .pair(pair), .start_addr(start_addr),
        .data_in(data_in), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".we"}, 64'(mem_we), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
    endtask

    task automatic scramble_cfg();
        iterations = ADDR_W'($urandom);
        period     = PERIOD_W'($urandom);
        delay      = PERIOD_W'($urandom);
        pair       = 1'($urandom);
        start_addr = ADDR_W'($urandom);
    endtask

    // One operation. Cycle k=0 is the first cycle after the acceptance edge.
    // Expected writes: window w spans cycles D+w*P .. D+w*P+P-1; captured words
    // appear on the memory port the cycle after they are sampled.
    task automatic do_op(input int n, input int per, input int dly, input bit pr,
                         input int sa, input bit hold, input bit ramp, input int abort_k);
        int p, e, idx, cyc;
        bit pe;
        bit ewe[MAXC];
        int eaddr[MAXC];
        int esrc[MAXC];
        logic [DATA_W-1:0] dat[MAXC];

        p  = (per == 0) ? 1 : per;
        pe = pr && (p >= 2);
        e  = dly + n * p;
        for (int i = 0; i < MAXC; i++) begin
            ewe[i] = 1'b0; eaddr[i] = 0; esrc[i] = 0;
            dat[i] = ramp ? DATA_W'(i) : DATA_W'($urandom);
        end
        idx = 0;
        for (int w = 0; w < n; w++) begin
            for (int c = (pe ? 2 : 1); c >= 1; c--) begin
                cyc = dly + w * p + p - c;
                ewe[cyc + 1]   = 1'b1;
                eaddr[cyc + 1] = (sa + idx) % AMOD;
                esrc[cyc + 1]  = cyc;
                idx++;
            end
        end

        @(negedge clk);
        check("accept.busy", 64'(busy), 64'd0);
        run        = 1'b1;
        iterations = ADDR_W'(n);
        period     = PERIOD_W'(per);
        delay      = PERIOD_W'(dly);
        pair       = pr;
        start_addr = ADDR_W'(sa);

        for (int k = 0; k <= e; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                run = 1'b0;
                #1;
                check_quiet("abort.now");
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check_quiet("abort.after");
                end
                return;
            end
            check("we", 64'(mem_we), 64'(ewe[k]));
            if (ewe[k]) begin
                check("addr", 64'(mem_addr), 64'(eaddr[k]));
                check("data", 64'(mem_data), 64'(dat[esrc[k]]));
            end
            check("busy", 64'(busy), 64'(k < e));
            check("done", 64'(done), 64'(k == e));
            data_in = dat[k];
            run = hold ? 1'b1 : 1'($urandom);
            scramble_cfg();
        end
    endtask

    initial begin
        #1;
        check_quiet("reset");
        check("reset.addr", 64'(mem_addr), 64'd0);
        check("reset.data", 64'(mem_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle");

        // basic, delay, pair, degenerate periods
        do_op(3, 4, 0, 1'b0, 0, 1'b0, 1'b1, -1);
        do_op(3, 4, 5, 1'b0, 0, 1'b0, 1'b1, -1);
        do_op(2, 3, 0, 1'b1, 'h10, 1'b0, 1'b0, -1);
        do_op(4, 0, 0, 1'b0, 7, 1'b0, 1'b0, -1);
        do_op(3, 1, 2, 1'b1, 20, 1'b0, 1'b0, -1);
        do_op(2, 2, 0, 1'b1, 30, 1'b0, 1'b0, -1);

        // iterations = 0 does nothing
        @(negedge clk);
        run = 1'b1; iterations = '0; period = 4; delay = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            run = 1'b0;
            check_quiet("iter0");
        end

        // address wrap, then back-to-back with run held high
        do_op(2, 3, 1, 1'b0, AMOD - 1, 1'b0, 1'b0, -1);
        do_op(2, 4, 0, 1'b0, 100, 1'b1, 1'b0, -1);
        do_op(3, 2, 3, 1'b1, AMOD - 3, 1'b1, 1'b0, -1);
        do_op(1, 5, 0, 1'b0, 200, 1'b0, 1'b0, -1);

        // reset mid-run after the first window, then a clean restart
        do_op(3, 4, 0, 1'b0, 50, 1'b0, 1'b0, 5);
        do_op(3, 4, 0, 1'b0, 50, 1'b0, 1'b0, -1);

        for (int t = 0; t < 25; t++) begin
            do_op($urandom_range(1, 5), $urandom_range(0, 6), $urandom_range(0, 6),
                  1'($urandom), $urandom_range(0, AMOD - 1), 1'($urandom), 1'b0, -1);
        end

        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check_quiet("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
